// File: rtl/itch_pkg.sv
// Shared constants and types for the ITCH message front end and decoder bank.
package itch_pkg;

    localparam int MAX_BYTES = 64;

    localparam logic [7:0] TYPE_ADD     = 8'h41;  // 'A'
    localparam logic [7:0] TYPE_EXECUTE = 8'h45;  // 'E'
    localparam logic [7:0] TYPE_CANCEL  = 8'h58;  // 'X'
    localparam logic [7:0] TYPE_DELETE  = 8'h44;  // 'D'
    localparam logic [7:0] TYPE_REPLACE = 8'h55;  // 'U'

    localparam int DISP_ADD     = 0;
    localparam int DISP_EXECUTE = 1;
    localparam int DISP_CANCEL  = 2;
    localparam int DISP_DELETE  = 3;
    localparam int DISP_REPLACE = 4;
    localparam int DISP_W       = 5;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        BODY,
        SKIP,
        DISPATCH
    } state_t;

endpackage

// File: rtl/itch_type_decode.sv
// Maps an ITCH message-type byte to a one-hot decoder select plus a known flag.
module itch_type_decode
    import itch_pkg::*;
(
    input  logic [7:0]        type_byte,
    output logic [DISP_W-1:0] onehot,
    output logic              known
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        onehot = '0;
        case (type_byte)
            TYPE_ADD:     onehot[DISP_ADD]     = 1'b1;
            TYPE_EXECUTE: onehot[DISP_EXECUTE] = 1'b1;
            TYPE_CANCEL:  onehot[DISP_CANCEL]  = 1'b1;
            TYPE_DELETE:  onehot[DISP_DELETE]  = 1'b1;
            TYPE_REPLACE: onehot[DISP_REPLACE] = 1'b1;
            default:      ;
        endcase
        known = |onehot;
    end

endmodule

// File: rtl/itch_msg_dispatcher.sv
// Length-prefixed ITCH stream framer: assembles each message left-aligned and
// strobes the decoder chosen by its type byte; bad frames are skipped and counted.
module itch_msg_dispatcher #(
    parameter int MAX_BYTES = itch_pkg::MAX_BYTES,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [8*MAX_BYTES-1:0]      payload,
    output logic [itch_pkg::DISP_W-1:0] dispatch,
    output logic [15:0]                 msg_len,
    output logic [CNT_W-1:0]            msg_count,
    output logic [CNT_W-1:0]            drop_count,
    output logic [CNT_W-1:0]            unknown_count
);
    import itch_pkg::*;

    localparam int          PW      = 8 * MAX_BYTES;
    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    state_t            state;
    logic [15:0]       len_q;
    logic [15:0]       idx;       // body byte index in BODY, bytes left in SKIP
    logic [PW-1:0]     buffer;
    logic [PW-1:0]     buf_next;
    logic [15:0]       len_full;
    logic              accept;
    logic [DISP_W-1:0] type_onehot;
    logic              type_known;

    assign accept   = in_valid && in_ready;
    assign len_full = {len_q[15:8], in_data};

    // The buffer is zeroed at frame start, so OR-ing the shifted byte places it.
    assign buf_next = buffer | ({in_data, {(PW-8){1'b0}}} >> {idx, 3'b000});

    // Decode from buf_next so a 1-byte message sees its own type byte.
    itch_type_decode u_type_decode (
        .type_byte (buf_next[PW-1 -: 8]),
        .onehot    (type_onehot),
        .known     (type_known)
    );

    // NOTE: the assembly buffer has no reset; it is cleared at the start of every frame.
    always_ff @(posedge clk) begin
        if (state == LEN_LO && accept) begin
            buffer <= '0;
        end else if (state == BODY && accept) begin
            buffer <= buf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LEN_HI;
            in_ready      <= 1'b1;
            len_q         <= '0;
            idx           <= '0;
            payload       <= '0;
            msg_len       <= '0;
            dispatch      <= '0;
            msg_count     <= '0;
            drop_count    <= '0;
            unknown_count <= '0;
        end else begin
            dispatch <= '0;
            case (state)
                LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= in_data;
                        state       <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_q <= len_full;
                        if (len_full == 16'd0) begin
                            drop_count <= drop_count + 1'b1;
                            state      <= LEN_HI;
                        end else if (len_full > MAX_LEN) begin
                            drop_count <= drop_count + 1'b1;
                            idx        <= len_full;
                            state      <= SKIP;
                        end else begin
                            idx   <= '0;
                            state <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (accept) begin
                        idx <= idx + 16'd1;
                        if (idx == len_q - 16'd1) begin
                            // Outputs register here so they are visible in the DISPATCH cycle.
                            payload  <= buf_next;
                            msg_len  <= len_q;
                            dispatch <= type_onehot;
                            if (type_known) msg_count     <= msg_count + 1'b1;
                            else            unknown_count <= unknown_count + 1'b1;
                            in_ready <= 1'b0;
                            state    <= DISPATCH;
                        end
                    end
                end
                SKIP: begin
                    if (accept) begin
                        idx <= idx - 16'd1;
                        if (idx == 16'd1) state <= LEN_HI;
                    end
                end
                DISPATCH: begin
                    in_ready <= 1'b1;
                    state    <= LEN_HI;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= LEN_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_itch_msg_dispatcher.sv
// Scoreboard bench for itch_msg_dispatcher: the driver queues expected dispatches,
// a negedge monitor compares them whenever the DUT sits in its dispatch cycle.
module tb_itch_msg_dispatcher;

    localparam int PW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] payload;
    logic [4:0]    dispatch;
    logic [15:0]   msg_len;
    logic [15:0]   msg_count;
    logic [15:0]   drop_count;
    logic [15:0]   unknown_count;

    itch_msg_dispatcher #(.MAX_BYTES(64), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .payload       (payload),
        .dispatch      (dispatch),
        .msg_len       (msg_len),
        .msg_count     (msg_count),
        .drop_count    (drop_count),
        .unknown_count (unknown_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    disp;
        logic [15:0]   len;
        logic [PW-1:0] payload;
    } exp_t;

    exp_t       exp_q[$];
    int         disp_cycles[$];
    logic [7:0] body[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         exp_msg = 0;
    int         exp_drop = 0;
    int         exp_unk = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cycle++;

    // Monitor: in_ready low marks the dispatch cycle; every such cycle must match a queued frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready === 1'b0) begin
                disp_cycles.push_back(cycle);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_dispatch_cycle", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_dispatch", dispatch, e.disp);
                    check("sb_msg_len", msg_len, e.len);
                    check("sb_payload", payload, e.payload);
                end
            end else begin
                check("stray_strobe", dispatch, 0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int guard;
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) check("in_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sends length prefix plus body; queues the expected dispatch for well-formed lengths.
    task automatic send_frame(input logic [4:0] exp_disp, input int max_gap);
        int   len;
        exp_t e;
        len = body.size();
        if (len == 0 || len > 64) begin
            exp_drop++;
        end else begin
            e.disp    = exp_disp;
            e.len     = 16'(len);
            e.payload = '0;
            for (int i = 0; i < len; i++) e.payload[511-8*i -: 8] = body[i];
            exp_q.push_back(e);
            if (exp_disp != 5'b0) exp_msg++;
            else                  exp_unk++;
        end
        send_byte(len[15:8], max_gap);
        send_byte(len[7:0], max_gap);
        for (int i = 0; i < len; i++) send_byte(body[i], max_gap);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_msg_count"}, msg_count, exp_msg);
        check({tag, "_drop_count"}, drop_count, exp_drop);
        check({tag, "_unknown_count"}, unknown_count, exp_unk);
    endtask

    task automatic load_add_frame();
        body = '{8'h41,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                 8'h53,
                 8'h00, 8'h00, 8'h00, 8'h64,
                 8'h4D, 8'h53, 8'h46, 8'h54,
                 8'h00, 8'h0F, 8'h42, 8'h40};
    endtask

    task automatic load_filled(input logic [7:0] type_byte, input int len, input logic [7:0] seed);
        body.delete();
        body.push_back(type_byte);
        for (int i = 1; i < len; i++) body.push_back(seed + 8'(i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_dispatch", dispatch, 0);
        check("rst_payload", payload, 0);
        check("rst_msg_len", msg_len, 0);
        check_counters("rst");

        // Add order, gap-free
        load_add_frame();
        send_frame(5'b00001, 0);
        idle(3);
        check("add_order_ref", payload[503:440], 64'h0102030405060708);
        check("add_shares", payload[431:400], 32'd100);
        check("add_price", payload[367:336], 32'd1000000);
        check_counters("add");

        // Back-to-back D (19) then X (23) with in_valid held high
        base = disp_cycles.size();
        load_filled(8'h44, 19, 8'h10);
        send_frame(5'b01000, 0);
        load_filled(8'h58, 23, 8'h80);
        send_frame(5'b00100, 0);
        idle(3);
        if (disp_cycles.size() >= base + 2)
            check("dx_strobe_spacing", disp_cycles[base+1] - disp_cycles[base], 26);
        else
            check("dx_strobe_count", disp_cycles.size() - base, 2);
        check("x_unused_bytes_zero", payload[327:0], 0);
        check_counters("dx");

        // Oversize (65), zero length, then an 'E' frame
        load_filled(8'h41, 65, 8'h20);
        send_frame(5'b00000, 0);
        body.delete();
        send_frame(5'b00000, 0);
        load_filled(8'h45, 11, 8'h30);
        send_frame(5'b00010, 0);
        idle(3);
        check_counters("drop");

        // Exactly MAX_BYTES is dispatched
        load_filled(8'h55, 64, 8'h40);
        send_frame(5'b10000, 0);
        idle(3);
        check("max_len_last_byte", payload[7:0], 8'h40 + 8'd63);

        // Unknown type 'S'
        load_filled(8'h53, 12, 8'h50);
        send_frame(5'b00000, 0);
        idle(3);
        check("unknown_type_byte", payload[511:504], 8'h53);
        check_counters("unknown");

        // Add order again with random in_valid gaps, including between length bytes
        load_add_frame();
        send_frame(5'b00001, 3);
        idle(3);
        check("stall_order_ref", payload[503:440], 64'h0102030405060708);
        check("stall_price", payload[367:336], 32'd1000000);
        check_counters("stall");

        // Reset after 10 body bytes of a 32-byte frame, then a complete 'U' frame
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        for (int i = 0; i < 10; i++) send_byte(8'h55 + 8'(i), 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_msg  = 0;
        exp_drop = 0;
        exp_unk  = 0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_dispatch", dispatch, 0);
        check("midrst_payload", payload, 0);
        check_counters("midrst");
        load_filled(8'h55, 27, 8'h60);
        send_frame(5'b10000, 0);
        idle(3);
        check_counters("after_rst");

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
